// File: rtl/cust_pkg.sv
// cust_pkg: default sizing and the {num,time} queue-entry layout shared by the service queue.
package cust_pkg;
    localparam int DT_SZ_D = 4;
    localparam int DEPTH_D = 3;
    localparam int PTR_W_D = 2;
    localparam int CNTER_D = 3;
    // Field slots, in units of DT_SZ, inside an entry {num,time}
    localparam int NUM_FLD = 1;
    localparam int TIME_FLD = 0;
endpackage

// File: rtl/cust_fifo.sv
// cust_fifo: circular waiting queue with a flattened head-first debug view.
module cust_fifo import cust_pkg::*; #(
    parameter int W = 2 * DT_SZ_D,
    parameter int DEPTH = DEPTH_D,
    parameter int PTR_W = PTR_W_D
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [W-1:0]         din,
    output logic                 full,
    output logic [PTR_W-1:0]     count,
    output logic [W-1:0]         head,
    output logic [DEPTH*W-1:0]   dbg
);
    logic [W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd, wr;
    logic do_push, do_pop;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return p == PTR_W'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign full = count == PTR_W'(DEPTH);
    assign do_pop = pop && count != '0;
    // A pop frees the slot the push lands in, so a full queue still accepts it
    assign do_push = push && (!full || do_pop);
    assign head = mem[rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wr] <= din;
                wr <= nxt(wr);
            end
            if (do_pop) rd <= nxt(rd);
            count <= count + PTR_W'(do_push) - PTR_W'(do_pop);
        end
    end

    always_comb begin
        dbg = '0;
        for (int j = 0; j < DEPTH; j++)
            dbg[j*W +: W] = j < int'(count) ? mem[(int'(rd) + j) % DEPTH] : '0;
    end
endmodule

// File: rtl/top.sv
// top: multi-counter service desk; arrivals go straight to the lowest free counter or wait in a FIFO.
module top import cust_pkg::*; #(
    parameter int DT_SZ = DT_SZ_D,
    parameter int DEPTH = DEPTH_D,
    parameter int PTR_W = PTR_W_D,
    parameter int CNTER = CNTER_D
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DT_SZ-1:0]           in_num,
    input  logic [DT_SZ-1:0]           in_time,
    output logic [CNTER*DT_SZ-1:0]     num_bus,
    output logic [CNTER*DT_SZ-1:0]     clk_bus,
    output logic [DEPTH*2*DT_SZ-1:0]   qdbg
);
    localparam int SW = CNTER > 1 ? $clog2(CNTER) : 1;
    localparam int EW = 2 * DT_SZ;

    logic [DT_SZ-1:0] num_r [CNTER];
    logic [DT_SZ-1:0] tm_r [CNTER];
    logic [SW-1:0] sel;
    logic any_free, arrive, empty, direct, pop, push, full;
    logic [PTR_W-1:0] count;
    logic [EW-1:0] head, ld;

    cust_fifo #(.W(EW), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk(clk), .rst(rst_n), .push(push), .pop(pop), .din({in_num, in_time}),
        .full(full), .count(count), .head(head), .dbg(qdbg)
    );

    // Lowest-index counter whose time already reads 0 this cycle
    always_comb begin
        sel = '0;
        any_free = 1'b0;
        for (int i = CNTER - 1; i >= 0; i--)
            if (tm_r[i] == '0) begin
                sel = SW'(i);
                any_free = 1'b1;
            end
    end

    assign arrive = in_valid && in_time != '0;
    assign empty = count == '0;
    assign pop = !empty && any_free;
    assign direct = arrive && empty && any_free;
    assign push = arrive && !direct && (!full || pop);
    assign ld = pop ? head : {in_num, in_time};

    always_ff @(posedge clk) begin
        for (int i = 0; i < CNTER; i++)
            if (rst_n) begin
                num_r[i] <= '0;
                tm_r[i] <= '0;
            end else if ((pop || direct) && sel == SW'(i)) begin
                num_r[i] <= ld[NUM_FLD*DT_SZ +: DT_SZ];
                tm_r[i] <= ld[TIME_FLD*DT_SZ +: DT_SZ];
            end else if (tm_r[i] != '0) begin
                tm_r[i] <= tm_r[i] - 1'b1;
                if (tm_r[i] == DT_SZ'(1)) num_r[i] <= '0;
            end
    end

    for (genvar k = 0; k < CNTER; k++) begin : g_out
        assign num_bus[k*DT_SZ +: DT_SZ] = num_r[k];
        assign clk_bus[k*DT_SZ +: DT_SZ] = tm_r[k];
    end
endmodule

// File: tb/tb_top.sv
// tb_top: directed vector table plus short hand sequences for the service-desk queue.
module tb_top;
    logic clk = 1'b0;
    logic rst_n, in_valid;
    logic [3:0] in_num, in_time;
    logic [11:0] num_bus, clk_bus;
    logic [23:0] qdbg;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic rst;
        logic v;
        logic [3:0] n;
        logic [3:0] t;
        logic [11:0] num;
        logic [11:0] tm;
        logic [23:0] q;
    } vec_t;
    vec_t tbl [16];

    top dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_num(in_num), .in_time(in_time),
        .num_bus(num_bus), .clk_bus(clk_bus), .qdbg(qdbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [3:0] n, input logic [3:0] t);
        rst_n = r;
        in_valid = v;
        in_num = n;
        in_time = t;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic [11:0] num, input logic [11:0] tm, input logic [23:0] q);
        chk({nm, " num_bus"}, {12'h0, num_bus}, {12'h0, num});
        chk({nm, " clk_bus"}, {12'h0, clk_bus}, {12'h0, tm});
        chk({nm, " qdbg"}, qdbg, q);
    endtask

    initial begin
        // rst v  n  t     num     clk     qdbg
        tbl[0]  = '{1, 0, 0, 0, 12'h000, 12'h000, 24'h000000};
        tbl[1]  = '{0, 1, 1, 8, 12'h001, 12'h008, 24'h000000};
        tbl[2]  = '{0, 0, 0, 0, 12'h001, 12'h007, 24'h000000};
        tbl[3]  = '{0, 1, 2, 8, 12'h021, 12'h086, 24'h000000};
        tbl[4]  = '{0, 0, 0, 0, 12'h021, 12'h075, 24'h000000};
        tbl[5]  = '{0, 1, 3, 8, 12'h321, 12'h864, 24'h000000};
        tbl[6]  = '{0, 1, 4, 1, 12'h321, 12'h753, 24'h000041};
        tbl[7]  = '{0, 1, 5, 5, 12'h321, 12'h642, 24'h005541};
        tbl[8]  = '{0, 1, 6, 2, 12'h321, 12'h531, 24'h625541};
        tbl[9]  = '{0, 1, 7, 3, 12'h320, 12'h420, 24'h625541};
        tbl[10] = '{0, 1, 8, 2, 12'h324, 12'h311, 24'h826255};
        tbl[11] = '{0, 0, 0, 0, 12'h300, 12'h200, 24'h826255};
        tbl[12] = '{0, 0, 0, 0, 12'h305, 12'h105, 24'h008262};
        tbl[13] = '{1, 1, 9, 9, 12'h000, 12'h000, 24'h000000};
        tbl[14] = '{0, 1, 10, 0, 12'h000, 12'h000, 24'h000000};
        tbl[15] = '{0, 1, 10, 3, 12'h00a, 12'h003, 24'h000000};
        rst_n = 1'b1;
        in_valid = 1'b0;
        in_num = '0;
        in_time = '0;
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].n, tbl[i].t);
            chk_all($sformatf("vec%0d", i), tbl[i].num, tbl[i].tm, tbl[i].q);
        end
        // Countdown of the last direct load down to a cleared counter
        step(0, 0, 0, 0); chk_all("drain2", 12'h00a, 12'h002, 24'h0);
        step(0, 0, 0, 0); chk_all("drain1", 12'h00a, 12'h001, 24'h0);
        step(0, 0, 0, 0); chk_all("drain0", 12'h000, 12'h000, 24'h0);
        // A freed middle counter is preferred over the higher free one
        step(1, 0, 0, 0); chk_all("rst2", 12'h000, 12'h000, 24'h0);
        step(0, 1, 1, 15); chk_all("gap_a", 12'h001, 12'h00f, 24'h0);
        step(0, 1, 2, 1); chk_all("gap_b", 12'h021, 12'h01e, 24'h0);
        step(0, 0, 0, 0); chk_all("gap_c", 12'h001, 12'h00d, 24'h0);
        step(0, 1, 3, 2); chk_all("gap_d", 12'h031, 12'h02c, 24'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 SHALL have parameter DT_SZ, default 4, giving the bit width of customer number and service time.
REQ-002 SHALL have parameter DEPTH, default 3, giving the number of waiting-queue (FIFO) entries.
REQ-003 SHALL have parameter PTR_W, default 2, giving the FIFO pointer/count width, equal to ceil(log2(DEPTH+1)).
REQ-004 SHALL have parameter CNTER, default 3, giving the number of service counters.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-high (rst_n=1 resets), sampled at the rising edge of clk.
REQ-007 SHALL have port in_valid, input, 1 bit: a customer arrival is presented this cycle.
REQ-008 SHALL have port in_num, input, DT_SZ bits: the arriving customer's number.
REQ-009 SHALL have port in_time, input, DT_SZ bits: the arriving customer's service time in cycles.
REQ-010 SHALL have port num_bus, output, CNTER*DT_SZ bits: the customer number at each counter; counter i occupies slice [i*DT_SZ +: DT_SZ].
REQ-011 SHALL have port clk_bus, output, CNTER*DT_SZ bits: the remaining service time at each counter, with the same slicing as num_bus.
REQ-012 SHALL have port qdbg, output, DEPTH*2*DT_SZ bits: a FIFO debug view in which entry j is {num,time} at [j*2*DT_SZ +: 2*DT_SZ].
- Entry 0 is the head of the queue.
- Unoccupied entries read 0.

Function
REQ-013 SHALL treat counter i as free when its clk_bus slice equals 0, and busy otherwise.
REQ-014 SHALL decrement each busy counter's remaining time by 1 every cycle; when the time reaches 0, the counter's num is also cleared to 0 on that same edge.
REQ-015 SHALL make a counter that was busy at the start of a cycle unavailable for loading in that cycle; it is first loadable in the cycle after its time reads 0.
REQ-016 SHALL pop at most one FIFO entry per cycle; if the FIFO is non-empty and any counter is free, the head SHALL load into the lowest-index free counter, setting num to the entry's num and time to the entry's time.
REQ-017 SHALL handle an arrival (in_valid=1 and in_time != 0) with an empty FIFO and a free counter by loading it directly into the lowest-index free counter, which becomes visible on the outputs after that rising edge.
REQ-018 SHALL, when the FIFO is non-empty, push every arrival to the FIFO tail even if a counter is free, to preserve FIFO order; in that same cycle the head pops per REQ-016.
REQ-019 SHALL push an arrival to the FIFO tail when no counter is free.
REQ-020 SHALL silently drop an arrival when the FIFO is full and no pop occurs in that cycle; if a pop occurs in the same cycle, the push SHALL be accepted.
REQ-021 SHALL ignore arrivals with in_time=0.
REQ-022 SHALL use a circular FIFO with read/write pointers that wrap modulo DEPTH and a PTR_W-bit count ranging 0..DEPTH; a simultaneous push and pop SHALL leave the count unchanged.
REQ-023 SHALL reflect the FIFO contents on qdbg in queue order starting from the head, updated on the same edge as the push or pop.

Reset
REQ-024 SHALL, while rst_n=1 at a rising edge, clear all counters (num_bus=0, clk_bus=0), empty the FIFO (pointers and count 0), and set qdbg=0.
REQ-025 SHALL ignore inputs during reset; reset mid-operation SHALL discard all in-service and queued customers.

Structure
REQ-026 SHALL keep the default parameter values and the {num,time} entry field layout in a shared package.
REQ-027 SHALL implement the FIFO as a sub-module cust_fifo (push/pop/full/empty/count/head/debug flatten); counter allocation (lowest-free priority encoder) and decrement logic SHALL stay in top.

Verification
REQ-028 SHALL cover this scenario: after reset, arrivals (1,8),(2,8),(3,8) every two cycles -> counters 0/1/2 hold nums 1/2/3, each clk_bus value decrementing from 8, FIFO empty.
REQ-029 SHALL cover this scenario: with all counters busy, arrivals (4,1),(5,5),(6,2) -> qdbg entry0={4,1}, entry1={5,5}, entry2={6,2}, full.
REQ-030 SHALL cover this scenario: with the FIFO full and no counter freeing, arrival (7,3) -> dropped, qdbg unchanged.
REQ-031 SHALL cover this scenario: counter 0 reaches 0 -> the next edge loads {4,1} into counter 0, the FIFO shifts to entry0={5,5}, and num/clk of counter 0 read 4/1 then 0/0.
REQ-032 SHALL cover this scenario: a full FIFO with a same-cycle pop and arrival (8,2) -> the push is accepted and the count stays 3.
REQ-033 SHALL cover this scenario: reset asserted mid-operation with busy counters and a non-empty FIFO -> all outputs are 0 on the next edge.
